// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared widths, serializer state encoding and a word-select
//               helper for the AES output serializer slice.
// Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_WORD_W    = 32;
  localparam int WORDS_PER_BLK = 4;

  // Serializer states: idle, then one state per 32-bit word of the block.
  typedef enum logic [2:0] {
    SER_IDLE = 3'd0,
    SER_W0   = 3'd1,
    SER_W1   = 3'd2,
    SER_W2   = 3'd3,
    SER_W3   = 3'd4
  } ser_state_t;

  // Word idx of a block, most significant word first (idx 0 = bits 127:96).
  function automatic logic [AES_WORD_W-1:0] blk_word(input logic [AES_BLK_W-1:0] blk,
                                                     input logic [1:0]           idx);
    logic [AES_WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_blk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_blk_fifo
// Description : Synchronous block FIFO, power-of-two depth. A push while full
//               is accepted only when a pop happens in the same cycle;
//               otherwise it is silently ignored (the caller flags the drop).
// Ports       : clk, reset (async, active-low)
//               push/wdata  - write request and data
//               pop         - remove head (ignored when empty)
//               rdata       - current head entry
//               rdata_nxt   - entry behind the head (valid when count >= 2)
//               full/empty/count - occupancy status
// Revision    : 1.0  initial release
// ============================================================================
module aes_blk_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [WIDTH-1:0]         rdata_nxt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             wr_en;
  logic             rd_en;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign rd_en      = pop && !empty;
  // A pop frees the slot the simultaneous push needs.
  assign wr_en      = push && (!full || rd_en);
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign rdata      = mem[rd_ptr];
  assign rdata_nxt  = mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_out_serializer
// Description : Tracks real blocks through the fixed-latency AES pipeline,
//               captures each matching cryptokey into a FIFO and streams it
//               out as four 32-bit words (MSW first) on valid/ready. Returns
//               an issue credit so a well-behaved upstream never overruns.
// Ports       : clk        - clock, rising edge
//               reset      - async, active-low
//               blk_issue  - real block presented to aes_top this cycle
//               issue_ok   - credit available for blk_issue
//               cryptokey  - 128-bit ciphertext from aes_top
//               m_data/m_valid/m_ready/m_last - word stream out
//               overflow   - sticky, a block was dropped on a full FIFO
// Revision    : 1.0  initial release
// ============================================================================
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int PIPE_LAT   = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_issue,
  output logic                  issue_ok,
  input  logic [AES_BLK_W-1:0]  cryptokey,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  logic [PIPE_LAT-1:0]  tag;
  logic                 tap;
  logic [CNT_W-1:0]     outstanding;
  logic                 pop;
  logic                 drop;
  logic                 more_queued;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic [AES_BLK_W-1:0] head;
  logic [AES_BLK_W-1:0] head_nxt;
  ser_state_t           state;

  // The oldest tag marks the cycle its cryptokey is on the bus.
  assign tap         = tag[PIPE_LAT-1];
  assign pop         = m_valid && m_ready && (state == SER_W3);
  assign drop        = tap && fifo_full && !pop;
  assign more_queued = (fifo_count > FCW'(1));
  // Credit covers blocks still in the pipeline plus those already buffered.
  assign issue_ok    = (outstanding < CNT_W'(FIFO_DEPTH));

  aes_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AES_BLK_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tap),
    .pop       (pop),
    .wdata     (cryptokey),
    .rdata     (head),
    .rdata_nxt (head_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag         <= '0;
      outstanding <= '0;
      overflow    <= 1'b0;
    end else begin
      tag <= {tag[PIPE_LAT-2:0], blk_issue};
      // A tag moving into the FIFO leaves the total unchanged; a dropped tag
      // or a popped entry reduces it.
      outstanding <= outstanding + CNT_W'(blk_issue) - CNT_W'(pop) - CNT_W'(drop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs are registered; each word is loaded on the edge entering its
  // state, so a stalled word simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SER_IDLE;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (!fifo_empty) begin
            state   <= SER_W0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            m_data  <= blk_word(head, 2'd0);
          end
        end
        SER_W0: begin
          if (m_ready) begin
            state  <= SER_W1;
            m_data <= blk_word(head, 2'd1);
          end
        end
        SER_W1: begin
          if (m_ready) begin
            state  <= SER_W2;
            m_data <= blk_word(head, 2'd2);
          end
        end
        SER_W2: begin
          if (m_ready) begin
            state  <= SER_W3;
            m_last <= 1'b1;
            m_data <= blk_word(head, 2'd3);
          end
        end
        SER_W3: begin
          if (m_ready) begin
            m_last <= 1'b0;
            // Only an entry already written behind the head can follow
            // without a bubble; one arriving this same cycle goes via IDLE.
            if (more_queued) begin
              state  <= SER_W0;
              m_data <= blk_word(head_nxt, 2'd0);
            end else begin
              state   <= SER_IDLE;
              m_valid <= 1'b0;
            end
          end
        end
        default: begin
          state   <= SER_IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
